// File: rtl/sdram_wr_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_wr_arb_pkg
// Shared definitions for the SDRAM write-port arbiter:
//   - arb_state_e     : FSM state encoding (IDLE / WRITE / HOLD / ABORT)
//   - DEF_ADDR_W      : default SDRAM write address width (Bank+Row+Column)
//   - DEF_DATA_W      : default width of each of the four write data words
//   - DEF_TIMEOUT_CYC : default write-done timeout in cycles
//   - GRANT_W         : width of the grant index (covers up to 8 requesters)
// ABORT is only reachable when SDRAM_WR_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
package sdram_wr_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_HOLD  = 2'd2,
      ST_ABORT = 2'd3
   } arb_state_e;

   localparam int DEF_ADDR_W      = 24;
   localparam int DEF_DATA_W      = 16;
   localparam int DEF_TIMEOUT_CYC = 4096;
   localparam int GRANT_W         = 3;

endpackage

// File: rtl/sdram_wr_arbiter_picker.sv
// ---------------------------------------------------------------------------
// rr_priority_picker
// Combinational round-robin picker. Searches the request vector starting at
// (last_grant_i + 1) mod NUM_REQ and returns the first set index.
// Ports:
//   req_i        in  NUM_REQ  request vector
//   last_grant_i in  3        index granted most recently
//   valid_o      out 1        at least one request is set
//   idx_o        out 3        winning requester index
// ---------------------------------------------------------------------------
module rr_priority_picker
   import sdram_wr_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [GRANT_W-1:0] last_grant_i,
   output logic               valid_o,
   output logic [GRANT_W-1:0] idx_o
);

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      // First pass: indices above last_grant. Descending scan so the lowest
      // matching index is the one left standing.
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (req_i[j] && (j > int'(last_grant_i))) begin
            valid_o = 1'b1;
            idx_o   = GRANT_W'(j);
         end
      end
      // Wrap-around pass: indices up to and including last_grant.
      if (!valid_o) begin
         for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_i[j] && (j <= int'(last_grant_i))) begin
               valid_o = 1'b1;
               idx_o   = GRANT_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/sdram_wr_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_wr_arbiter
// Round-robin arbiter sharing one SDRAM write port among NUM_REQ requesters.
// The winner's address and four data words are latched in IDLE, one write
// runs at a time, and a one-cycle done pulse goes back to the owner only.
//
// Handshake: a requester raises iReq[k] (level) with its address/data slice
// valid and keeps it high until it sees oDone[k]; it should drop iReq[k] in
// the cycle oDone[k] is high (the HOLD cycle gives it time to do so). Toward
// the controller, oSDRAM_Wr_Req stays high with stable address/data until
// iSDRAM_Wr_Done is sampled high in WRITE; done outside WRITE is ignored.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   en                  block enable; low forces IDLE
//   iReq                per-requester request level
//   iAddr, iData1..4    flattened per-requester address/data (slice k = req k)
//   oDone               one-cycle done pulse to the owner
//   oSDRAM_Wr_Addr/Data1..4/Req  registered write port to the controller
//   iSDRAM_Wr_Done      write-complete pulse from the controller
//   oGrant_Id           current or last granted requester
//   oBusy               high outside IDLE
//   oTimeout            sticky write timeout flag
// Optional feature: define SDRAM_WR_ARB_TIMEOUT_EN to abort a write after
// TIMEOUT_CYC cycles without done; otherwise WRITE waits forever and
// oTimeout is tied low.
// ---------------------------------------------------------------------------
module sdram_wr_arbiter
   import sdram_wr_arb_pkg::*;
#(
   parameter int NUM_REQ     = 2,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [NUM_REQ-1:0]        iReq,
   input  logic [NUM_REQ*ADDR_W-1:0] iAddr,
   input  logic [NUM_REQ*DATA_W-1:0] iData1,
   input  logic [NUM_REQ*DATA_W-1:0] iData2,
   input  logic [NUM_REQ*DATA_W-1:0] iData3,
   input  logic [NUM_REQ*DATA_W-1:0] iData4,
   output logic [NUM_REQ-1:0]        oDone,
   output logic [ADDR_W-1:0]         oSDRAM_Wr_Addr,
   output logic [DATA_W-1:0]         oSDRAM_Wr_Data1,
   output logic [DATA_W-1:0]         oSDRAM_Wr_Data2,
   output logic [DATA_W-1:0]         oSDRAM_Wr_Data3,
   output logic [DATA_W-1:0]         oSDRAM_Wr_Data4,
   output logic                      oSDRAM_Wr_Req,
   input  logic                      iSDRAM_Wr_Done,
   output logic [GRANT_W-1:0]        oGrant_Id,
   output logic                      oBusy,
   output logic                      oTimeout
);

   arb_state_e         state_q, state_d;
   logic [GRANT_W-1:0] last_grant_q, last_grant_d;
   logic [GRANT_W-1:0] grant_q, grant_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  data1_q, data1_d, data2_q, data2_d;
   logic [DATA_W-1:0]  data3_q, data3_d, data4_q, data4_d;
   logic               wr_req_q, wr_req_d;
   logic [NUM_REQ-1:0] done_q, done_d;
   logic               busy_q, busy_d;
`ifdef SDRAM_WR_ARB_TIMEOUT_EN
   logic               timeout_q, timeout_d;
   logic [15:0]        cnt_q, cnt_d;
`endif

   logic               pick_valid;
   logic [GRANT_W-1:0] pick_idx;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_d1, sel_d2, sel_d3, sel_d4;
   logic [NUM_REQ-1:0] grant_onehot;

   rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
      .req_i        (iReq),
      .last_grant_i (last_grant_q),
      .valid_o      (pick_valid),
      .idx_o        (pick_idx)
   );

   // Slice selection for the picked requester.
   always_comb begin
      sel_addr = '0;
      sel_d1   = '0;
      sel_d2   = '0;
      sel_d3   = '0;
      sel_d4   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick_idx == GRANT_W'(k)) begin
            sel_addr = iAddr [k*ADDR_W +: ADDR_W];
            sel_d1   = iData1[k*DATA_W +: DATA_W];
            sel_d2   = iData2[k*DATA_W +: DATA_W];
            sel_d3   = iData3[k*DATA_W +: DATA_W];
            sel_d4   = iData4[k*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      grant_onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         grant_onehot[k] = (grant_q == GRANT_W'(k));
      end
   end

   // Next-state logic; every output is registered from these _d values.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      data1_d      = data1_q;
      data2_d      = data2_q;
      data3_d      = data3_q;
      data4_d      = data4_q;
      wr_req_d     = wr_req_q;
      done_d       = '0;
`ifdef SDRAM_WR_ARB_TIMEOUT_EN
      timeout_d    = timeout_q;
      cnt_d        = '0;
`endif
      if (!en) begin
         // Disabled: abandon any write, keep last_grant and latched payload.
         state_d  = ST_IDLE;
         wr_req_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (pick_valid) begin
                  state_d  = ST_WRITE;
                  grant_d  = pick_idx;
                  addr_d   = sel_addr;
                  data1_d  = sel_d1;
                  data2_d  = sel_d2;
                  data3_d  = sel_d3;
                  data4_d  = sel_d4;
                  wr_req_d = 1'b1;
               end
            end
            ST_WRITE: begin
               // Done has priority over a timeout hitting in the same cycle.
               if (iSDRAM_Wr_Done) begin
                  state_d      = ST_HOLD;
                  wr_req_d     = 1'b0;
                  done_d       = grant_onehot;
                  last_grant_d = grant_q;
               end
`ifdef SDRAM_WR_ARB_TIMEOUT_EN
               else if (cnt_q == 16'(TIMEOUT_CYC - 1)) begin
                  // Aborted writes still advance the rotation so a dead
                  // requester cannot monopolise the port.
                  state_d      = ST_ABORT;
                  wr_req_d     = 1'b0;
                  done_d       = grant_onehot;
                  last_grant_d = grant_q;
                  timeout_d    = 1'b1;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
`endif
            end
            ST_HOLD:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_HOLD;
            default:  state_d = ST_IDLE;
         endcase
      end
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_W'(NUM_REQ - 1);
         grant_q      <= '0;
         addr_q       <= '0;
         data1_q      <= '0;
         data2_q      <= '0;
         data3_q      <= '0;
         data4_q      <= '0;
         wr_req_q     <= 1'b0;
         done_q       <= '0;
         busy_q       <= 1'b0;
`ifdef SDRAM_WR_ARB_TIMEOUT_EN
         timeout_q    <= 1'b0;
         cnt_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         data1_q      <= data1_d;
         data2_q      <= data2_d;
         data3_q      <= data3_d;
         data4_q      <= data4_d;
         wr_req_q     <= wr_req_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
`ifdef SDRAM_WR_ARB_TIMEOUT_EN
         timeout_q    <= timeout_d;
         cnt_q        <= cnt_d;
`endif
      end
   end

   assign oDone           = done_q;
   assign oSDRAM_Wr_Addr  = addr_q;
   assign oSDRAM_Wr_Data1 = data1_q;
   assign oSDRAM_Wr_Data2 = data2_q;
   assign oSDRAM_Wr_Data3 = data3_q;
   assign oSDRAM_Wr_Data4 = data4_q;
   assign oSDRAM_Wr_Req   = wr_req_q;
   assign oGrant_Id       = grant_q;
   assign oBusy           = busy_q;
`ifdef SDRAM_WR_ARB_TIMEOUT_EN
   assign oTimeout        = timeout_q;
`else
   assign oTimeout        = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_wr_arbiter
// Bench for sdram_wr_arbiter with two requesters. Expected grant/payload
// tuples {id, addr, d1, d2, d3, d4} are queued when requests are driven and
// popped when the write port comes up. Define SDRAM_WR_ARB_TIMEOUT_EN for
// both bench and RTL to exercise the timeout path (TIMEOUT_CYC = 16).
// ---------------------------------------------------------------------------
module tb_sdram_wr_arbiter;

   localparam int NR = 2;
   localparam int AW = 24;
   localparam int DW = 16;
   localparam int TO = 16;
   localparam int PW = 3 + AW + 4*DW;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b1;
   logic [NR-1:0]     iReq = '0;
   logic [NR*AW-1:0]  iAddr = '0;
   logic [NR*DW-1:0]  iData1 = '0, iData2 = '0, iData3 = '0, iData4 = '0;
   logic              iSDRAM_Wr_Done = 1'b0;
   logic [NR-1:0]     oDone;
   logic [AW-1:0]     oSDRAM_Wr_Addr;
   logic [DW-1:0]     oSDRAM_Wr_Data1, oSDRAM_Wr_Data2, oSDRAM_Wr_Data3, oSDRAM_Wr_Data4;
   logic              oSDRAM_Wr_Req;
   logic [2:0]        oGrant_Id;
   logic              oBusy;
   logic              oTimeout;

   logic [PW-1:0]     exp_q[$];
   int                n_cmp = 0;
   int                n_bad = 0;

   sdram_wr_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .iReq(iReq), .iAddr(iAddr),
      .iData1(iData1), .iData2(iData2), .iData3(iData3), .iData4(iData4),
      .oDone(oDone), .oSDRAM_Wr_Addr(oSDRAM_Wr_Addr),
      .oSDRAM_Wr_Data1(oSDRAM_Wr_Data1), .oSDRAM_Wr_Data2(oSDRAM_Wr_Data2),
      .oSDRAM_Wr_Data3(oSDRAM_Wr_Data3), .oSDRAM_Wr_Data4(oSDRAM_Wr_Data4),
      .oSDRAM_Wr_Req(oSDRAM_Wr_Req), .iSDRAM_Wr_Done(iSDRAM_Wr_Done),
      .oGrant_Id(oGrant_Id), .oBusy(oBusy), .oTimeout(oTimeout)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got hang want finish");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      en = 1'b1;
      iReq = '0;
      iSDRAM_Wr_Done = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drive_req(input int k, input logic [AW-1:0] a,
                            input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                            input logic [DW-1:0] w3, input logic [DW-1:0] w4);
      iAddr [k*AW +: AW] = a;
      iData1[k*DW +: DW] = w1;
      iData2[k*DW +: DW] = w2;
      iData3[k*DW +: DW] = w3;
      iData4[k*DW +: DW] = w4;
      iReq[k] = 1'b1;
   endtask

   task automatic wait_wr_req(output int w);
      w = 0;
      while (oSDRAM_Wr_Req !== 1'b1 && w < 50) begin
         @(posedge clk);
         @(negedge clk);
         w++;
      end
   endtask

   // Serve one SDRAM write: wait for the request, check the payload against
   // the scoreboard, answer done after 'delay' request cycles, check oDone.
   task automatic serve_one(input int delay, input bit change_mid, input bit drop,
                            output int wcnt);
      logic [PW-1:0] exp;
      logic [NR-1:0] exp_done;
      int            hi;
      bit            stable;
      wait_wr_req(wcnt);
      n_cmp++;
      if (oSDRAM_Wr_Req !== 1'b1) begin
         n_bad++;
         $display("FAIL wr_req_rise: got %b want 1 after %0d cycles", oSDRAM_Wr_Req, wcnt);
         return;
      end
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_bad++;
         $display("FAIL scoreboard_empty: got write want none queued");
         return;
      end
      exp = exp_q.pop_front();
      exp_done = NR'(1) << exp[PW-1 -: 3];
      if ({oGrant_Id, oSDRAM_Wr_Addr, oSDRAM_Wr_Data1, oSDRAM_Wr_Data2,
           oSDRAM_Wr_Data3, oSDRAM_Wr_Data4} !== exp) begin
         n_bad++;
         $display("FAIL grant_payload: got id=%0d addr=%h d1=%h want id=%0d addr=%h d1=%h",
                  oGrant_Id, oSDRAM_Wr_Addr, oSDRAM_Wr_Data1,
                  exp[PW-1 -: 3], exp[PW-4 -: AW], exp[4*DW-1 -: DW]);
      end
      hi = 1;
      stable = 1'b1;
      for (int i = 1; i < delay; i++) begin
         @(posedge clk);
         #1;
         if (change_mid && i == 2) iData1[0 +: DW] = 16'h001F;
         @(negedge clk);
         if (oSDRAM_Wr_Req === 1'b1) hi++;
         if ({oGrant_Id, oSDRAM_Wr_Addr, oSDRAM_Wr_Data1, oSDRAM_Wr_Data2,
              oSDRAM_Wr_Data3, oSDRAM_Wr_Data4} !== exp || oDone !== '0) stable = 1'b0;
      end
      iSDRAM_Wr_Done = 1'b1;
      @(posedge clk);
      #1 iSDRAM_Wr_Done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (stable !== 1'b1) begin
         n_bad++;
         $display("FAIL payload_stable: got changed want stable during WRITE");
      end
      n_cmp++;
      if (hi != delay) begin
         n_bad++;
         $display("FAIL req_len: got %0d want %0d cycles", hi, delay);
      end
      n_cmp++;
      if (oSDRAM_Wr_Req !== 1'b0 || oDone !== exp_done) begin
         n_bad++;
         $display("FAIL done_pulse: got req=%b done=%b want req=0 done=%b",
                  oSDRAM_Wr_Req, oDone, exp_done);
      end
      if (drop) iReq[exp[PW-1 -: 3]] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (oDone !== '0 || oBusy !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_end: got done=%b busy=%b want done=0 busy=0", oDone, oBusy);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({oDone, oSDRAM_Wr_Addr, oSDRAM_Wr_Data1, oSDRAM_Wr_Data2, oSDRAM_Wr_Data3,
           oSDRAM_Wr_Data4, oSDRAM_Wr_Req, oGrant_Id, oBusy, oTimeout} !== '0) begin
         n_bad++;
         $display("FAIL reset_outputs: got req=%b busy=%b grant=%0d addr=%h want all 0",
                  oSDRAM_Wr_Req, oBusy, oGrant_Id, oSDRAM_Wr_Addr);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int w;
      apply_reset();
      drive_req(1, 24'h012345, 16'hF800, 16'hF800, 16'hF800, 16'hF800);
      exp_q.push_back({3'd1, 24'h012345, 16'hF800, 16'hF800, 16'hF800, 16'hF800});
      serve_one(5, 1'b0, 1'b1, w);
      n_cmp++;
      if (w != 1) begin
         n_bad++;
         $display("FAIL single_latency: got %0d want 1 cycle", w);
      end
   endtask

   task automatic test_round_robin();
      int w;
      apply_reset();
      drive_req(0, 24'h000100, 16'h07E0, 16'h0001, 16'h0002, 16'h0003);
      drive_req(1, 24'h000200, 16'hF800, 16'h0011, 16'h0012, 16'h0013);
      for (int i = 0; i < 6; i++) begin
         if (i % 2 == 0)
            exp_q.push_back({3'd0, 24'h000100, 16'h07E0, 16'h0001, 16'h0002, 16'h0003});
         else
            exp_q.push_back({3'd1, 24'h000200, 16'hF800, 16'h0011, 16'h0012, 16'h0013});
      end
      for (int i = 0; i < 6; i++) begin
         serve_one(1 + $urandom_range(0, 3), 1'b0, 1'b0, w);
         n_cmp++;
         if (w != 1) begin
            n_bad++;
            $display("FAIL rr_spacing[%0d]: got %0d want 1 cycle to next req", i, w);
         end
      end
      iReq = '0;
   endtask

   task automatic test_data_hold();
      int w;
      apply_reset();
      drive_req(0, 24'h0ABCDE, 16'h07E0, 16'h1111, 16'h2222, 16'h3333);
      exp_q.push_back({3'd0, 24'h0ABCDE, 16'h07E0, 16'h1111, 16'h2222, 16'h3333});
      serve_one(6, 1'b1, 1'b1, w);
   endtask

   task automatic test_reset_mid_write();
      int w;
      apply_reset();
      drive_req(1, 24'h00AAAA, 16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
      wait_wr_req(w);
      n_cmp++;
      if (oSDRAM_Wr_Req !== 1'b1 || oGrant_Id !== 3'd1) begin
         n_bad++;
         $display("FAIL rst_mid_grant: got req=%b id=%0d want req=1 id=1", oSDRAM_Wr_Req, oGrant_Id);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({oDone, oSDRAM_Wr_Addr, oSDRAM_Wr_Data1, oSDRAM_Wr_Data2, oSDRAM_Wr_Data3,
           oSDRAM_Wr_Data4, oSDRAM_Wr_Req, oGrant_Id, oBusy, oTimeout} !== '0) begin
         n_bad++;
         $display("FAIL rst_mid_outputs: got req=%b busy=%b grant=%0d want all 0",
                  oSDRAM_Wr_Req, oBusy, oGrant_Id);
      end
      rst_n = 1'b1;
      drive_req(0, 24'h00BBBB, 16'h4321, 16'h8765, 16'hCBA9, 16'h0FED);
      exp_q.push_back({3'd0, 24'h00BBBB, 16'h4321, 16'h8765, 16'hCBA9, 16'h0FED});
      serve_one(3, 1'b0, 1'b1, w);
      n_cmp++;
      if (w != 1) begin
         n_bad++;
         $display("FAIL rst_mid_regrant: got %0d want 1 cycle", w);
      end
      iReq = '0;
   endtask

   task automatic test_en_drop();
      int w;
      apply_reset();
      drive_req(1, 24'h00F00F, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
      wait_wr_req(w);
      n_cmp++;
      if (oSDRAM_Wr_Req !== 1'b1 || oGrant_Id !== 3'd1) begin
         n_bad++;
         $display("FAIL en_grant: got req=%b id=%0d want req=1 id=1", oSDRAM_Wr_Req, oGrant_Id);
      end
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++;
         if (oSDRAM_Wr_Req !== 1'b0 || oBusy !== 1'b0 || oDone !== '0) begin
            n_bad++;
            $display("FAIL en_low[%0d]: got req=%b busy=%b done=%b want 0 0 00",
                     i, oSDRAM_Wr_Req, oBusy, oDone);
         end
      end
      en = 1'b1;
      exp_q.push_back({3'd1, 24'h00F00F, 16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00});
      serve_one(2, 1'b0, 1'b1, w);
      n_cmp++;
      if (w != 1) begin
         n_bad++;
         $display("FAIL en_regrant: got %0d want 1 cycle", w);
      end
   endtask

   task automatic test_timeout();
      int w;
      int hi;
      apply_reset();
      drive_req(0, 24'h0DEAD0, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      wait_wr_req(w);
      hi = (oSDRAM_Wr_Req === 1'b1) ? 1 : 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (oSDRAM_Wr_Req === 1'b1) hi++;
         else break;
      end
`ifdef SDRAM_WR_ARB_TIMEOUT_EN
      n_cmp++;
      if (hi != TO || oDone !== 2'b01 || oTimeout !== 1'b1) begin
         n_bad++;
         $display("FAIL timeout_abort: got len=%0d done=%b to=%b want len=%0d done=01 to=1",
                  hi, oDone, oTimeout, TO);
      end
      iReq = '0;
      repeat (4) begin
         @(posedge clk);
         @(negedge clk);
      end
      n_cmp++;
      if (oTimeout !== 1'b1 || oDone !== '0 || oBusy !== 1'b0) begin
         n_bad++;
         $display("FAIL timeout_sticky: got to=%b done=%b busy=%b want 1 00 0",
                  oTimeout, oDone, oBusy);
      end
`else
      n_cmp++;
      if (hi != 41 || oTimeout !== 1'b0 || oDone !== '0) begin
         n_bad++;
         $display("FAIL no_timeout: got len=%0d to=%b done=%b want len=41 to=0 done=00",
                  hi, oTimeout, oDone);
      end
      iReq = '0;
`endif
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_data_hold();
      test_reset_mid_write();
      test_en_drop();
      test_timeout();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
